// File: rtl/dram_uart_tx_pkg.sv
// Shared definitions for the DRAM-to-UART transmitter: default sizes and the
// state encodings of the fetch controller and the bit serializer.
package dram_uart_tx_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 16;
    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_NUM_BYTES    = 16384;
    localparam int unsigned DEF_CLKS_PER_BIT = 434;

    // Fetch controller: SEND spans the START/DATA/STOP phases of the serializer.
    typedef enum logic [2:0] {
        CTRL_IDLE  = 3'd0,
        CTRL_FETCH = 3'd1,
        CTRL_WAIT  = 3'd2,
        CTRL_SEND  = 3'd3,
        CTRL_DONE  = 3'd4
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_e;

    // Width of a down-counter that must hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dram_uart_tx_serializer.sv
// 8N1-style UART serializer: start bit, DATA_WIDTH data bits LSB first, one stop bit,
// each lasting CLKS_PER_BIT clocks. tx idles high.
module dram_uart_tx_serializer
    import dram_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  tx,
    output logic                  ready
);

    localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = cnt_width(DATA_WIDTH);

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

    ser_state_e            state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  baud_wrap;

    assign baud_wrap = (baud_q == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SER_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its held value first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            SER_IDLE: begin
                if (load) begin
                    shift_d = data;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_RELOAD;
                    state_d = SER_START;
                end
            end
            SER_START: begin
                if (baud_wrap) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    baud_d  = BAUD_RELOAD;
                    state_d = SER_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            SER_DATA: begin
                if (baud_wrap) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = SER_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            SER_STOP: begin
                if (baud_wrap) begin
                    state_d = SER_IDLE;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    assign tx = tx_q;
    // Also high in the last stop-bit cycle so the controller can start the next fetch without a bubble.
    assign ready = (state_q == SER_IDLE) || ((state_q == SER_STOP) && baud_wrap);

endmodule

// File: rtl/dram_uart_tx.sv
// Streams NUM_BYTES bytes from DRAM address 0 upward out of a UART pin, once per
// rising edge of start_Tx; edges seen while a transfer is running are dropped.
module dram_uart_tx
    import dram_uart_tx_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned NUM_BYTES    = DEF_NUM_BYTES,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_Tx,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic                  dram_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    // Truncation is intended: NUM_BYTES == 2**ADDR_WIDTH ends on the all-ones address.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BYTES - 1);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  start_prev_q;
    logic                  read_en_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  request;
    logic                  ser_load;
    logic                  ser_ready;

    assign request = start_Tx & ~start_prev_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ser_load = 1'b0;
        case (state_q)
            CTRL_IDLE: begin
                if (request) begin
                    addr_d  = '0;
                    state_d = CTRL_FETCH;
                end
            end
            CTRL_FETCH: state_d = CTRL_WAIT;
            CTRL_WAIT: begin
                // Read data is valid this cycle; the serializer is idle and captures it.
                ser_load = 1'b1;
                state_d  = CTRL_SEND;
            end
            CTRL_SEND: begin
                if (ser_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = CTRL_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = CTRL_FETCH;
                    end
                end
            end
            CTRL_DONE: state_d = CTRL_IDLE;
            default:   state_d = CTRL_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= CTRL_IDLE;
            addr_q       <= '0;
            start_prev_q <= 1'b0;
            read_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            start_prev_q <= start_Tx;
            read_en_q    <= (state_d == CTRL_FETCH);
            busy_q       <= (state_d == CTRL_FETCH) || (state_d == CTRL_WAIT) || (state_d == CTRL_SEND);
            done_q       <= (state_d == CTRL_DONE);
        end
    end

    dram_uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_serializer (
        .clock(clock),
        .reset(reset),
        .load (ser_load),
        .data (dram_rdata),
        .tx   (tx),
        .ready(ser_ready)
    );

    assign dram_addr    = addr_q;
    assign dram_read_en = read_en_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_dram_uart_tx.sv
// Randomized scoreboard bench: expected bytes are queued when a transfer is requested,
// and a UART-decoding monitor pops and compares each frame seen on the line.
module tb_dram_uart_tx;

    localparam int CPB  = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int NB_A = 3;

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic [AW-1:0] addr_a, addr_b;
    logic rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    logic [DW-1:0] mem_a [0:NB_A-1];
    logic [DW-1:0] mem_b;

    int checks = 0;
    int failures = 0;
    int done_cnt_a = 0, done_cnt_b = 0, rd_cnt_a = 0, rd_cnt_b = 0;
    int addr_err = 0;
    int frames_seen = 0;

    logic [DW-1:0] exp_q [$];
    logic mon_armed, sel_b;
    logic mon_tx, mon_busy, mon_done;

    assign mon_tx   = sel_b ? tx_b   : tx_a;
    assign mon_busy = sel_b ? busy_b : busy_a;
    assign mon_done = sel_b ? done_b : done_a;

    dram_uart_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(NB_A), .CLKS_PER_BIT(CPB)) dut_a (
        .clock(clk), .reset(rst), .start_Tx(start_a), .dram_rdata(rdata_a),
        .dram_addr(addr_a), .dram_read_en(rd_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    dram_uart_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(1), .CLKS_PER_BIT(CPB)) dut_b (
        .clock(clk), .reset(rst), .start_Tx(start_b), .dram_rdata(rdata_b),
        .dram_addr(addr_b), .dram_read_en(rd_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM models with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_a === 1'b1) begin
            if (int'(addr_a) < NB_A) rdata_a <= mem_a[addr_a[1:0]];
            else begin
                rdata_a  <= 'x;
                addr_err <= addr_err + 1;
            end
        end
        if (rd_b === 1'b1) begin
            if (addr_b != '0) addr_err <= addr_err + 1;
            rdata_b <= mem_b;
        end
    end

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
        if (rd_a === 1'b1)   rd_cnt_a   <= rd_cnt_a + 1;
        if (rd_b === 1'b1)   rd_cnt_b   <= rd_cnt_b + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input bit on_b, input int base, input string name);
        int n = 0;
        while (((on_b ? done_cnt_b : done_cnt_a) <= base) && n < 2000) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 32'((on_b ? done_cnt_b : done_cnt_a) > base), 1);
    endtask

    task automatic push_a();
        for (int i = 0; i < NB_A; i++) exp_q.push_back(mem_a[i]);
    endtask

    task automatic randomize_a();
        for (int i = 0; i < NB_A; i++) mem_a[i] = 8'($urandom);
    endtask

    task automatic finish_a(input string name, input int db, input int rb);
        wait_done(1'b0, db, name);
        repeat (4) tick();
        check({name, "_reads"}, rd_cnt_a - rb, NB_A);
        check({name, "_done_pulses"}, done_cnt_a - db, 1);
        check({name, "_busy_after"}, busy_a, 0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    // Monitor: decodes frames from the selected line and compares against the scoreboard.
    initial begin : monitor
        logic [DW-1:0] got;
        logic shape_ok;
        logic have_start;
        have_start = 1'b0;
        forever begin
            if (!have_start) begin
                @(negedge clk);
                if (!(mon_armed === 1'b1) || mon_tx !== 1'b0) continue;
            end
            have_start = 1'b0;
            shape_ok   = 1'b1;
            got        = '0;
            repeat (CPB - 1) begin
                @(negedge clk);
                if (mon_tx !== 1'b0) shape_ok = 1'b0;
            end
            for (int b = 0; b < DW; b++) begin
                for (int j = 0; j < CPB; j++) begin
                    @(negedge clk);
                    if (j == 0) got[b] = mon_tx;
                    else if (mon_tx !== got[b]) shape_ok = 1'b0;
                end
            end
            repeat (CPB) begin
                @(negedge clk);
                if (mon_tx !== 1'b1) shape_ok = 1'b0;
            end
            frames_seen++;
            check("frame_bit_timing", shape_ok, 1);
            check("frame_was_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("frame_byte", got, exp_q.pop_front());
            @(negedge clk);
            if (mon_done === 1'b1) begin
                check("done_busy_low", mon_busy, 0);
                check("done_tx_idle", mon_tx, 1);
            end else begin
                shape_ok = (mon_tx === 1'b1) && (mon_busy === 1'b1);
                @(negedge clk);
                if (mon_tx !== 1'b1) shape_ok = 1'b0;
                @(negedge clk);
                check("interframe_gap", {shape_ok, mon_tx}, 2'b10);
                have_start = (mon_tx === 1'b0);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int db, rb, lat, n;
        logic ok;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mon_armed = 1'b0;
        sel_b = 1'b0;
        mem_b = '0;
        for (int i = 0; i < NB_A; i++) mem_a[i] = '0;

        repeat (3) tick();
        check("reset_outputs", {tx_a, busy_a, done_a, rd_a}, 4'b1000);
        check("reset_addr", addr_a, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_after_reset", {tx_a, busy_a}, 2'b10);

        // Fixed pattern, plus request-to-start-bit latency.
        mem_a[0] = 8'hA5; mem_a[1] = 8'h3C; mem_a[2] = 8'hFF;
        mon_armed = 1'b1;
        db = done_cnt_a; rb = rd_cnt_a;
        push_a();
        @(posedge clk); #1 start_a = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && tx_a === 1'b0) lat = k;
        end
        check("start_to_tx_latency", lat, 3);
        finish_a("basic", db, rb);

        // start_Tx held high must not retrigger; a fresh edge must.
        db = done_cnt_a; rb = rd_cnt_a; ok = 1'b1;
        repeat (500) begin
            tick();
            if (tx_a !== 1'b1 || busy_a !== 1'b0) ok = 1'b0;
        end
        check("held_start_line_idle", ok, 1);
        check("held_start_no_reads", rd_cnt_a - rb, 0);
        check("held_start_no_done", done_cnt_a - db, 0);
        start_a = 1'b0;
        repeat (3) tick();
        randomize_a();
        db = done_cnt_a; rb = rd_cnt_a;
        push_a();
        @(posedge clk); #1 start_a = 1'b1;
        finish_a("retrigger", db, rb);

        // An edge in the middle of frame 2 is dropped, not queued.
        start_a = 1'b0;
        repeat (3) tick();
        randomize_a();
        db = done_cnt_a; rb = rd_cnt_a;
        push_a();
        @(posedge clk); #1 start_a = 1'b1;
        n = 0;
        while (rd_cnt_a - rb < 2 && n < 300) begin
            tick();
            n++;
        end
        repeat (15) tick();
        check("mid_frame_busy", busy_a, 1);
        start_a = 1'b0;
        tick(); tick();
        start_a = 1'b1;
        finish_a("ignored_edge", db, rb);
        repeat (100) tick();
        check("no_queued_transfer", rd_cnt_a - rb, NB_A);

        // Reset in the data bits of frame 1.
        mon_armed = 1'b0;
        start_a = 1'b0;
        mem_a[0] = 8'h00;
        repeat (3) tick();
        @(posedge clk); #1 start_a = 1'b1;
        n = 0;
        while (tx_a !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("abort_frame_started", tx_a, 0);
        repeat (CPB + 10) @(posedge clk);
        #1;
        check("abort_in_data_bits", {tx_a, busy_a}, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("async_reset_outputs", {tx_a, busy_a, rd_a, done_a}, 4'b1000);
        check("async_reset_addr", addr_a, 0);
        start_a = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b0;
        rb = rd_cnt_a; ok = 1'b1;
        repeat (50) begin
            tick();
            if (tx_a !== 1'b1 || busy_a !== 1'b0) ok = 1'b0;
        end
        check("post_reset_line_idle", ok, 1);
        check("post_reset_no_reads", rd_cnt_a - rb, 0);

        // start_Tx already high on the first edge after reset is a request.
        randomize_a();
        mon_armed = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        start_a = 1'b1;
        repeat (2) tick();
        db = done_cnt_a; rb = rd_cnt_a;
        push_a();
        @(negedge clk);
        rst = 1'b0;
        finish_a("start_high_at_reset", db, rb);

        // Single-byte transfers on the NUM_BYTES=1 instance.
        start_a = 1'b0;
        sel_b = 1'b1;
        repeat (3) tick();
        for (int t = 0; t < 2; t++) begin
            mem_b = (t == 0) ? 8'h01 : 8'($urandom);
            db = done_cnt_b; rb = rd_cnt_b;
            exp_q.push_back(mem_b);
            @(posedge clk); #1 start_b = 1'b1;
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                if (lat == 0 && tx_b === 1'b0) lat = k;
            end
            check("single_latency", lat, 3);
            wait_done(1'b1, db, "single");
            repeat (4) tick();
            check("single_reads", rd_cnt_b - rb, 1);
            check("single_done_pulses", done_cnt_b - db, 1);
            check("single_queue_drained", exp_q.size(), 0);
            start_b = 1'b0;
            repeat (3) tick();
        end

        check("dram_addr_in_range", addr_err, 0);
        check("total_frames", frames_seen, 14);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
